// File: rtl/axi_master.sv
// rtl/axi_master.sv - single-beat AXI master with independent write/read FSMs and per-FSM timeout
module axi_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        axi_ACLK,
    input  logic        axi_ARESET,
    // write address / data / response channels
    output logic [31:0] AWADDR,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY,
    // read address / data channels
    output logic [31:0] ARADDR,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RVALID,
    output logic        RREADY,
    // user write side
    input  logic        write_start_i,
    input  logic [31:0] write_address_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  write_strobe_i,
    output logic        write_done_o,
    output logic        write_error_o,
    output logic        write_busy_o,
    // user read side
    input  logic        read_start_i,
    input  logic [31:0] read_address_i,
    output logic [31:0] read_data_o,
    output logic        read_done_o,
    output logic        read_error_o,
    output logic        read_busy_o
);

    // A zero TIMEOUT_CYCLES disables the watchdog entirely.
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESPONSE} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDRESS, R_RESPONSE} rd_state_t;

    wr_state_t   wr_state;
    rd_state_t   rd_state;
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic wr_tmo, rd_tmo;

    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign b_hs   = BVALID & BREADY;
    assign ar_hs  = ARVALID & ARREADY;
    assign r_hs   = RVALID & RREADY;
    // Counter holds the number of completed non-idle cycles; the last allowed cycle is TMO_LAST.
    assign wr_tmo = TMO_EN && (wr_cnt >= TMO_LAST);
    assign rd_tmo = TMO_EN && (rd_cnt >= TMO_LAST);

    // Write FSM: AW and W handshakes tracked independently, then wait for B; handshakes beat timeout.
    always_ff @(posedge axi_ACLK) begin
        if (axi_ARESET) begin
            wr_state      <= W_IDLE;
            wr_cnt        <= '0;
            AWADDR        <= '0;
            WDATA         <= '0;
            WSTRB         <= '0;
            AWVALID       <= 1'b0;
            WVALID        <= 1'b0;
            BREADY        <= 1'b0;
            write_done_o  <= 1'b0;
            write_error_o <= 1'b0;
            write_busy_o  <= 1'b0;
        end else begin
            write_done_o  <= 1'b0;
            write_error_o <= 1'b0;
            case (wr_state)
                W_IDLE: begin
                    if (write_start_i) begin
                        AWADDR       <= write_address_i;
                        WDATA        <= write_data_i;
                        WSTRB        <= write_strobe_i;
                        AWVALID      <= 1'b1;
                        WVALID       <= 1'b1;
                        wr_cnt       <= '0;
                        write_busy_o <= 1'b1;
                        wr_state     <= W_ADDR_DATA;
                    end
                end
                W_ADDR_DATA: begin
                    if (aw_hs || w_hs) begin
                        if (aw_hs) AWVALID <= 1'b0;
                        if (w_hs)  WVALID  <= 1'b0;
                        if ((aw_hs || !AWVALID) && (w_hs || !WVALID)) begin
                            BREADY   <= 1'b1;
                            wr_state <= W_RESPONSE;
                        end
                        wr_cnt <= wr_cnt + 32'd1;
                    end else if (wr_tmo) begin
                        AWVALID       <= 1'b0;
                        WVALID        <= 1'b0;
                        write_done_o  <= 1'b1;
                        write_error_o <= 1'b1;
                        write_busy_o  <= 1'b0;
                        wr_state      <= W_IDLE;
                    end else begin
                        wr_cnt <= wr_cnt + 32'd1;
                    end
                end
                W_RESPONSE: begin
                    if (b_hs || wr_tmo) begin
                        BREADY        <= 1'b0;
                        write_done_o  <= 1'b1;
                        write_error_o <= b_hs ? (BRESP != 2'b00) : 1'b1;
                        write_busy_o  <= 1'b0;
                        wr_state      <= W_IDLE;
                    end else begin
                        wr_cnt <= wr_cnt + 32'd1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: AR handshake then R beat; read data only updates on an actual R handshake.
    always_ff @(posedge axi_ACLK) begin
        if (axi_ARESET) begin
            rd_state     <= R_IDLE;
            rd_cnt       <= '0;
            ARADDR       <= '0;
            ARVALID      <= 1'b0;
            RREADY       <= 1'b0;
            read_data_o  <= '0;
            read_done_o  <= 1'b0;
            read_error_o <= 1'b0;
            read_busy_o  <= 1'b0;
        end else begin
            read_done_o  <= 1'b0;
            read_error_o <= 1'b0;
            case (rd_state)
                R_IDLE: begin
                    if (read_start_i) begin
                        ARADDR      <= read_address_i;
                        ARVALID     <= 1'b1;
                        rd_cnt      <= '0;
                        read_busy_o <= 1'b1;
                        rd_state    <= R_ADDRESS;
                    end
                end
                R_ADDRESS: begin
                    if (ar_hs) begin
                        ARVALID  <= 1'b0;
                        RREADY   <= 1'b1;
                        rd_cnt   <= rd_cnt + 32'd1;
                        rd_state <= R_RESPONSE;
                    end else if (rd_tmo) begin
                        ARVALID      <= 1'b0;
                        read_done_o  <= 1'b1;
                        read_error_o <= 1'b1;
                        read_busy_o  <= 1'b0;
                        rd_state     <= R_IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + 32'd1;
                    end
                end
                R_RESPONSE: begin
                    if (r_hs) begin
                        read_data_o  <= RDATA;
                        read_error_o <= (RRESP != 2'b00);
                    end else if (rd_tmo) begin
                        read_error_o <= 1'b1;
                    end
                    if (r_hs || rd_tmo) begin
                        RREADY      <= 1'b0;
                        read_done_o <= 1'b1;
                        read_busy_o <= 1'b0;
                        rd_state    <= R_IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + 32'd1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_master.md
AXI_MASTER -- requirements
Module: axi_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles a transaction may stay outstanding (0 = timeout disabled).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 axi_ACLK  in  1  sole clock, all logic on rising edge.
REQ-004 axi_ARESET  in  1  synchronous active-high reset.
REQ-005 write_channel  axi_write_interface.master: AWADDR[31:0], AWVALID, WDATA[31:0], WSTRB[3:0], WVALID, BREADY out; AWREADY, WREADY, BRESP[1:0], BVALID in.
REQ-006 read_channel  axi_read_interface.master: ARADDR[31:0], ARVALID, RREADY out; ARREADY, RDATA[31:0], RRESP[1:0], RVALID in.
REQ-007 write_start_i  in  1  request pulse; sampled only when write FSM is IDLE.
REQ-008 write_address_i / write_data_i / write_strobe_i  in  32/32/4  write payload, captured with write_start_i.
REQ-009 write_done_o  out  1  one-cycle pulse at write completion.
REQ-010 write_error_o  out  1  valid with write_done_o: BRESP != OKAY or timeout.
REQ-011 write_busy_o  out  1  high whenever write FSM is not IDLE.
REQ-012 read_start_i  in  1  request pulse; sampled only when read FSM is IDLE.
REQ-013 read_address_i  in  32  read address, captured with read_start_i.
REQ-014 read_data_o  out  32  captured RDATA, held until next read completion.
REQ-015 read_done_o / read_error_o / read_busy_o  out  1 each  read counterparts of REQ-009..011.

Function
REQ-016 Write and read paths SHALL be independent FSMs; simultaneous write_start_i and read_start_i both accepted same cycle.
REQ-017 Write FSM states: IDLE, ADDR_DATA, RESPONSE.
REQ-018 IDLE + write_start_i in cycle N: payload registered, AWVALID=WVALID=1 from cycle N+1, state ADDR_DATA.
REQ-019 ADDR_DATA: AWVALID dropped cycle after AWVALID&AWREADY, WVALID dropped cycle after WVALID&WREADY; each handshake tracked separately; AWADDR/WDATA/WSTRB stable while respective VALID high.
REQ-020 Both handshakes complete (same or different cycles) -> RESPONSE with BREADY=1 next cycle.
REQ-021 RESPONSE: on BVALID&BREADY, BREADY=0, write_done_o=1 next cycle, write_error_o=(BRESP!=OKAY), state IDLE.
REQ-022 Read FSM states: IDLE, ADDRESS, RESPONSE; read_start_i in cycle N -> ARVALID=1 from N+1.
REQ-023 ADDRESS: ARVALID&ARREADY -> ARVALID=0, RREADY=1 next cycle, state RESPONSE.
REQ-024 RESPONSE: RVALID&RREADY -> read_data_o<=RDATA, read_error_o=(RRESP!=OKAY), read_done_o pulse next cycle, RREADY=0, IDLE.
REQ-025 Minimum latency start->done: write 3 cycles, read 3 cycles against zero-wait slave (READY/VALID already high).
REQ-026 VALID SHALL never deassert before its handshake except on timeout.
REQ-027 start_i while busy SHALL be ignored (no queuing, no state change).
REQ-028 Per-FSM timeout counter cleared on leaving IDLE, increments each non-IDLE cycle; reaching TIMEOUT_CYCLES forces all channel VALID/READY low, done=1, error=1, IDLE.
REQ-029 Handshake and timeout in same cycle: handshake wins, counter ignored.
REQ-030 done/error outputs SHALL be low in all cycles except the completion cycle; read_data_o unchanged on read timeout.

Reset
REQ-031 axi_ARESET=1 at any clock edge, including mid-transaction: both FSMs IDLE; AWVALID, WVALID, BREADY, ARVALID, RREADY, all done/error/busy = 0; read_data_o = 0; timeout counters = 0.
REQ-032 First start accepted on first edge with axi_ARESET=0.

Verification
REQ-033 Zero-wait write 0x0000_1000 / 0xDEADBEEF / WSTRB 0xF, BRESP OKAY -> done at N+3, error=0, AWADDR/WDATA match.
REQ-034 AWREADY delayed 4 cycles, WREADY immediate -> WVALID drops N+2, AWVALID held until AWREADY, single done, error=0.
REQ-035 Read 0x2000_0004, ARREADY after 2 cycles, RDATA 0xCAFEF00D RRESP SLVERR -> read_data_o=0xCAFEF00D, read_error_o=1.
REQ-036 TIMEOUT_CYCLES=8, slave never asserts AWREADY -> VALIDs drop, done+error pulse 8 cycles after entry, busy=0 after.
REQ-037 Simultaneous write and read start, plus extra starts while busy -> exactly one done each, extra starts ignored.
REQ-038 Reset asserted while in RESPONSE -> all outputs per REQ-031 next cycle, no done pulse.
